// File: rtl/bcd_multi_counter.sv
// Multi-digit BCD up/down counter; each digit has its own modulus, cascading in one cycle.
// count/roll/sat are registered (one edge); at_max/at_zero decode count combinationally.
module bcd_multi_counter #(
  parameter int                  DIGITS = 4,
  parameter logic [4*DIGITS-1:0] MAXV   = 16'h9999,
  parameter bit                  SAT    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  roll,
  output logic                  sat,
  output logic                  at_max,
  output logic                  at_zero
);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                roll_q, roll_d;
  logic                sat_q, sat_d;

  logic [4*DIGITS-1:0] step_val;
  logic [4*DIGITS-1:0] load_clamped;
  logic                carry;
  logic                all_max;
  logic                limit;
  logic [3:0]          cur_dig;
  logic [3:0]          max_dig;
  logic [3:0]          ld_dig;

  // Ripple the step through the digits: digit i moves only when every lower digit
  // sat at its turnover value (MAX going up, 0 going down).
  always_comb begin
    step_val     = count_q;
    load_clamped = '0;
    carry        = 1'b1;
    all_max      = 1'b1;
    cur_dig      = '0;
    max_dig      = '0;
    ld_dig       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      cur_dig = count_q[4*i +: 4];
      max_dig = MAXV[4*i +: 4];
      ld_dig  = load_val[4*i +: 4];
      if (carry) begin
        if (dir) step_val[4*i +: 4] = (cur_dig == max_dig) ? 4'd0 : cur_dig + 4'd1;
        else     step_val[4*i +: 4] = (cur_dig == 4'd0) ? max_dig : cur_dig - 4'd1;
      end
      carry = carry && (dir ? (cur_dig == max_dig) : (cur_dig == 4'd0));
      if (cur_dig != max_dig) all_max = 1'b0;
      load_clamped[4*i +: 4] = (ld_dig > max_dig) ? max_dig : ld_dig;
    end
  end

  assign limit = dir ? all_max : (count_q == '0);

  always_comb begin
    count_d = count_q;
    roll_d  = 1'b0;
    sat_d   = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_clamped;
    end else if (en) begin
      if (limit && SAT) begin
        sat_d = 1'b1;
      end else begin
        // At the limit the cascade itself yields all-zero (up) or MAXV (down).
        count_d = step_val;
        roll_d  = limit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      roll_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      roll_q  <= roll_d;
      sat_q   <= sat_d;
    end
  end

  assign count   = count_q;
  assign roll    = roll_q;
  assign sat     = sat_q;
  assign at_max  = all_max;
  assign at_zero = (count_q == '0);

endmodule

// File: tb/tb_bcd_multi_counter.sv
// Directed bench: three counter flavours (9999 wrap, 5959 wrap, 9999 saturate) share one stimulus.
module tb_bcd_multi_counter;

  logic        clk = 1'b0;
  logic        rst, clr, en, dir, load;
  logic [15:0] load_val;

  logic [15:0] cnt_a, cnt_b, cnt_s;
  logic        roll_a, roll_b, roll_s;
  logic        sat_a, sat_b, sat_s;
  logic        amax_a, amax_b, amax_s;
  logic        azero_a, azero_b, azero_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_multi_counter #(.DIGITS(4), .MAXV(16'h9999), .SAT(1'b0)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .count(cnt_a), .roll(roll_a), .sat(sat_a), .at_max(amax_a), .at_zero(azero_a));

  bcd_multi_counter #(.DIGITS(4), .MAXV(16'h5959), .SAT(1'b0)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .count(cnt_b), .roll(roll_b), .sat(sat_b), .at_max(amax_b), .at_zero(azero_b));

  bcd_multi_counter #(.DIGITS(4), .MAXV(16'h9999), .SAT(1'b1)) u_s (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .count(cnt_s), .roll(roll_s), .sat(sat_s), .at_max(amax_s), .at_zero(azero_s));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b0; dir = 1'b1; load = 1'b0; load_val = '0;
    step();

    // Reset after the counter has moved away from zero
    rst = 1'b0; load = 1'b1; load_val = 16'h1234;
    step();
    load = 1'b0; en = 1'b1;
    step();
    step();
    chk("pre_rst_count", cnt_a, 16'h1236);
    rst = 1'b1;
    step();
    chk("rst_count", cnt_a, 16'h0000);
    chk("rst_roll", {15'd0, roll_a}, 16'd0);
    chk("rst_sat", {15'd0, sat_s}, 16'd0);
    chk("rst_at_zero", {15'd0, azero_a}, 16'd1);
    rst = 1'b0; en = 1'b0;

    // Multi-digit carry 0999 -> 1000
    load = 1'b1; load_val = 16'h0999;
    step();
    chk("load_0999", cnt_a, 16'h0999);
    load = 1'b0; en = 1'b1; dir = 1'b1;
    step();
    chk("carry_1000", cnt_a, 16'h1000);
    chk("carry_roll", {15'd0, roll_a}, 16'd0);

    // Full-range wrap (SAT=0) and saturation (SAT=1)
    en = 1'b0; load = 1'b1; load_val = 16'h9999;
    step();
    chk("at_max_9999", {15'd0, amax_a}, 16'd1);
    load = 1'b0; en = 1'b1;
    step();
    chk("wrap_count", cnt_a, 16'h0000);
    chk("wrap_roll", {15'd0, roll_a}, 16'd1);
    chk("sat1_count", cnt_s, 16'h9999);
    chk("sat1_pulse", {15'd0, sat_s}, 16'd1);
    chk("sat1_roll", {15'd0, roll_s}, 16'd0);
    step();
    chk("post_wrap_count", cnt_a, 16'h0001);
    chk("roll_one_cycle", {15'd0, roll_a}, 16'd0);
    chk("sat2_count", cnt_s, 16'h9999);
    chk("sat2_pulse", {15'd0, sat_s}, 16'd1);
    step();
    chk("sat3_count", cnt_s, 16'h9999);
    chk("sat3_pulse", {15'd0, sat_s}, 16'd1);
    chk("sat3_roll", {15'd0, roll_s}, 16'd0);
    en = 1'b0;
    step();
    chk("sat_idle_drop", {15'd0, sat_s}, 16'd0);

    // Per-digit moduli: 0059 -> 0100 with MAXV 5959
    load = 1'b1; load_val = 16'h0059;
    step();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    step();
    chk("mod_up_0100", cnt_b, 16'h0100);
    en = 1'b0; clr = 1'b1;
    step();
    chk("clr_count", cnt_b, 16'h0000);
    chk("clr_at_zero", {15'd0, azero_b}, 16'd1);
    clr = 1'b0; en = 1'b1; dir = 1'b0;
    step();
    chk("mod_down_wrap", cnt_b, 16'h5959);
    chk("mod_down_roll", {15'd0, roll_b}, 16'd1);
    chk("mod_at_max", {15'd0, amax_b}, 16'd1);
    chk("down_wrap_9999", cnt_a, 16'h9999);
    chk("sat_down_hold", cnt_s, 16'h0000);
    chk("sat_down_pulse", {15'd0, sat_s}, 16'd1);
    en = 1'b0;
    step();
    chk("mod_roll_drop", {15'd0, roll_b}, 16'd0);

    // Load clamps digits above the digit's MAX and ignores en
    load = 1'b1; load_val = 16'h7A3F; en = 1'b1; dir = 1'b1;
    step();
    chk("clamp_9999", cnt_a, 16'h7939);
    chk("clamp_roll", {15'd0, roll_a}, 16'd0);
    chk("clamp_5959", cnt_b, 16'h5939);
    chk("clamp_sat", {15'd0, sat_s}, 16'd0);

    // clr beats load and en
    clr = 1'b1; load = 1'b1; load_val = 16'h4321; en = 1'b1;
    step();
    chk("clr_over_load", cnt_a, 16'h0000);
    chk("clr_over_load_roll", {15'd0, roll_a}, 16'd0);

    // Direction change each cycle
    clr = 1'b0; load = 1'b1; load_val = 16'h0500; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; dir = 1'b0;
    step();
    chk("dir_down_0499", cnt_a, 16'h0499);
    dir = 1'b1;
    step();
    chk("dir_up_0500", cnt_a, 16'h0500);
    en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
